// File: rtl/dmux_stream_pkg.sv
// rtl/dmux_stream_pkg.sv - package exposing dmux_stream defaults and the clog2 helper
package dmux_stream_pkg;
`include "dmux_defs.vh"

  localparam int DMUX_WIDTH = `DMUX_DEF_WIDTH;
  localparam int DMUX_N     = `DMUX_DEF_N;

endpackage

// File: rtl/dmux_defs.vh
// rtl/dmux_defs.vh - shared defaults, slot slice macro and clog2 helper for dmux_stream
`ifndef DMUX_DEFS_VH
`define DMUX_DEFS_VH

`define DMUX_DEF_WIDTH 16
`define DMUX_DEF_N 4
`define DMUX_SLOT(k, w) ((k)*(w)) +: (w)

function automatic int dmux_clog2(input int v);
  int r;
  r = 0;
  for (int x = v - 1; x > 0; x = x >> 1) r++;
  return r;
endfunction

`endif

// File: rtl/dmux_slot.sv
// rtl/dmux_slot.sv - one-entry output slot: data register plus full bit, reset to empty
module dmux_slot
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  // Load wins over drain so a same-cycle drain+refill keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// rtl/dmux_stream.sv - registered 1-to-N stream demux with per-channel slots
// Optional broadcast input enabled by DMUX_STREAM_BCAST_EN.
module dmux_stream
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH,
  parameter int N     = DMUX_N,
  parameter int SEL_W = (dmux_clog2(N) < 1) ? 1 : dmux_clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef DMUX_STREAM_BCAST_EN
  input  logic               bcast,
`endif
  output logic [N*WIDTH-1:0] out,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               sel_err
);

  logic [N-1:0] slot_free;
  logic [N-1:0] load;
  logic [N-1:0] drain;
  logic         sel_ok;
  logic         sel_free;
  logic         bcast_w;
  logic         accept;

`ifdef DMUX_STREAM_BCAST_EN
  assign bcast_w = bcast;
`else
  assign bcast_w = 1'b0;
`endif

  assign slot_free = ~out_valid | out_ready;
  assign drain     = out_valid & out_ready;
  assign sel_ok    = 32'(sel) < N;

  always_comb begin
    sel_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (32'(sel) == k) sel_free = slot_free[k];
    end
  end

  // Out-of-range words are always taken (and dropped) so they never stall the producer.
  assign in_ready = bcast_w ? &slot_free : (sel_ok ? sel_free : 1'b1);
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign load[k] = accept & (bcast_w | (32'(sel) == k));

    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .drain (drain[k]),
      .d     (in),
      .q     (out[k*WIDTH +: WIDTH]),
      .full  (out_valid[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (accept && !bcast_w && !sel_ok) begin
      sel_err <= 1'b1;
    end
  end

endmodule
